// File: rtl/bram_arb_pkg.sv
// rtl/bram_arb_pkg.sv - shared widths, BRAM word-index field and index-width helper
package bram_arb_pkg;

  localparam int DEF_ADDR_W    = 32;
  localparam int DEF_DATA_W    = 32;
  localparam int BRAM_WORD_LSB = 2;
  localparam int BRAM_WORD_MSB = 17;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - first set request at or after a start index, wrapping modulo N
module rr_picker #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [IW:0] pos;

  // Scan from farthest to nearest so the closest request to start overwrites the others.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    pos   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      pos = {1'b0, start} + (IW + 1)'(k);
      if (pos >= (IW + 1)'(N)) pos = pos - (IW + 1)'(N);
      if (req[pos[IW-1:0]]) begin
        grant              = '0;
        grant[pos[IW-1:0]] = 1'b1;
        idx                = pos[IW-1:0];
        any                = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bram_rd_arbiter.sv
// rtl/bram_rd_arbiter.sv - round-robin BRAM read-port arbiter with bounded burst hold
module bram_rd_arbiter
  import bram_arb_pkg::*;
#(
  parameter int NUM_REQ   = 2,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MAX_BURST = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      bram_en,
  output logic [ADDR_W-1:0]         bram_addr,
  input  logic [DATA_W-1:0]         bram_dout
);

  localparam int              IW        = idx_width(NUM_REQ);
  localparam int              CW        = $clog2(MAX_BURST) + 1;
  localparam logic [IW-1:0]   LAST_IDX  = IW'(NUM_REQ - 1);

  logic [IW-1:0]      owner;
  logic [IW-1:0]      rr_start;
  logic [IW-1:0]      pick_idx;
  logic [NUM_REQ-1:0] pick_grant;
  logic               pick_any;
  logic [CW-1:0]      burst_cnt;
  logic               below_lim;
  logic               hold;

  generate
    if (MAX_BURST > 1) begin : g_burst
      localparam logic [CW-1:0] BURST_LIM = CW'(MAX_BURST - 1);
      assign below_lim = (burst_cnt < BURST_LIM);
    end else begin : g_no_burst
      assign below_lim = 1'b0;
    end
  endgenerate

  // Explicit wrap keeps owner+1 legal when NUM_REQ is not a power of two.
  assign rr_start = (owner == LAST_IDX) ? '0 : owner + 1'b1;
  assign hold     = req_valid[owner] && below_lim;

  rr_picker #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_picker (
    .req   (req_valid),
    .start (rr_start),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  always_comb begin
    req_ready = '0;
    if (hold) req_ready[owner] = 1'b1;
    else      req_ready = pick_grant;
  end

  // A rotate that lands back on the owner (sole requester at the limit) also restarts the burst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner     <= '0;
      burst_cnt <= '0;
    end else if (hold) begin
      burst_cnt <= burst_cnt + 1'b1;
    end else if (pick_any) begin
      owner     <= pick_idx;
      burst_cnt <= '0;
    end
  end

  always_comb begin
    bram_addr = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_ready[i]) bram_addr = req_addr[i*ADDR_W +: ADDR_W];
    end
  end

  assign bram_en = |req_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rsp_valid <= '0;
    else     rsp_valid <= req_ready;
  end

  assign rsp_data = bram_dout;

endmodule
